// File: rtl/regfile_nr2w1.sv
// regfile_nr2w1: DEPTH x WIDTH register file, two registered read ports, one byte-strobed
// write port with same-cycle write-to-read forwarding and optional hardwired-zero entry 0.
module regfile_nr2w1 #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [WIDTH/8-1:0] wstrb_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic               re_a_i,
   input  logic [AW-1:0]      raddr_a_i,
   output logic [WIDTH-1:0]   dout_a_o,
   input  logic               re_b_i,
   input  logic [AW-1:0]      raddr_b_i,
   output logic [WIDTH-1:0]   dout_b_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
   logic             wr_ok;
   // Reads index the post-write array, so forwarding falls out of the next-state view.
   always_comb begin
      merged = mem_q[waddr_i];
      for (int i = 0; i < WIDTH/8; i++)
         merged[8*i +: 8] = wstrb_i[i] ? data_i[8*i +: 8] : mem_q[waddr_i][8*i +: 8];
      wr_ok = we_i && !(ZERO_REG != 0 && waddr_i == '0);
      mem_d = mem_q;
      if (wr_ok) mem_d[waddr_i] = merged;
      dout_a_d = !re_a_i ? dout_a_q : (ZERO_REG != 0 && raddr_a_i == '0) ? '0 : mem_d[raddr_a_i];
      dout_b_d = !re_b_i ? dout_b_q : (ZERO_REG != 0 && raddr_b_i == '0) ? '0 : mem_d[raddr_b_i];
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q    <= '{default: '0};
         dout_a_q <= '0;
         dout_b_q <= '0;
      end else begin
         mem_q    <= mem_d;
         dout_a_q <= dout_a_d;
         dout_b_q <= dout_b_d;
      end
   end
   assign dout_a_o = dout_a_q;
   assign dout_b_o = dout_b_q;
endmodule

// File: tb/tb_regfile_nr2w1.sv
// tb_regfile_nr2w1: directed checks of the register file in three configurations
// (32x32 with zero reg, 32x32 without, 16-bit x 8 with zero reg).
module tb_regfile_nr2w1;
   logic clk, rst_n;
   int   n_tests, n_fail;
   // main DUT: WIDTH=32, DEPTH=32, ZERO_REG=1
   logic        we, re_a, re_b;
   logic [4:0]  waddr, raddr_a, raddr_b;
   logic [3:0]  wstrb;
   logic [31:0] data, dout_a, dout_b;
   // no-zero DUT: WIDTH=32, DEPTH=32, ZERO_REG=0
   logic        n_we, n_re_a, n_re_b;
   logic [4:0]  n_waddr, n_raddr_a, n_raddr_b;
   logic [3:0]  n_wstrb;
   logic [31:0] n_data, n_dout_a, n_dout_b;
   // small DUT: WIDTH=16, DEPTH=8, ZERO_REG=1
   logic        s_we, s_re_a, s_re_b;
   logic [2:0]  s_waddr, s_raddr_a, s_raddr_b;
   logic [1:0]  s_wstrb;
   logic [15:0] s_data, s_dout_a, s_dout_b;

   regfile_nr2w1 #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .we_i(we), .waddr_i(waddr), .wstrb_i(wstrb), .data_i(data),
      .re_a_i(re_a), .raddr_a_i(raddr_a), .dout_a_o(dout_a),
      .re_b_i(re_b), .raddr_b_i(raddr_b), .dout_b_o(dout_b));
   regfile_nr2w1 #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut_nz (
      .clk_i(clk), .rst_n_i(rst_n), .we_i(n_we), .waddr_i(n_waddr), .wstrb_i(n_wstrb), .data_i(n_data),
      .re_a_i(n_re_a), .raddr_a_i(n_raddr_a), .dout_a_o(n_dout_a),
      .re_b_i(n_re_b), .raddr_b_i(n_raddr_b), .dout_b_o(n_dout_b));
   regfile_nr2w1 #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut_s (
      .clk_i(clk), .rst_n_i(rst_n), .we_i(s_we), .waddr_i(s_waddr), .wstrb_i(s_wstrb), .data_i(s_data),
      .re_a_i(s_re_a), .raddr_a_i(s_raddr_a), .dout_a_o(s_dout_a),
      .re_b_i(s_re_b), .raddr_b_i(s_raddr_b), .dout_b_o(s_dout_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0;
      we = 0; re_a = 0; re_b = 0; waddr = 0; raddr_a = 0; raddr_b = 0; wstrb = 0; data = 0;
      n_we = 0; n_re_a = 0; n_re_b = 0; n_waddr = 0; n_raddr_a = 0; n_raddr_b = 0; n_wstrb = 0; n_data = 0;
      s_we = 0; s_re_a = 0; s_re_b = 0; s_waddr = 0; s_raddr_a = 0; s_raddr_b = 0; s_wstrb = 0; s_data = 0;
      #3;
      chk("reset_a", dout_a, 32'h0);
      chk("reset_b", dout_b, 32'h0);
      #20 rst_n = 1'b1;
      // every entry reads zero after reset
      re_a = 1; re_b = 1;
      for (int a = 0; a < 32; a++) begin
         raddr_a = 5'(a); raddr_b = 5'(31 - a);
         tick();
         chk($sformatf("rst_rd_a%0d", a), dout_a, 32'h0);
         chk($sformatf("rst_rd_b%0d", a), dout_b, 32'h0);
      end
      re_a = 0; re_b = 0;
      // full write then partial strobed write
      we = 1; waddr = 5; data = 32'hDEADBEEF; wstrb = 4'b1111;
      tick();
      we = 0; re_a = 1; raddr_a = 5;
      tick();
      chk("wr_full", dout_a, 32'hDEADBEEF);
      re_a = 0; we = 1; waddr = 5; data = 32'h11223344; wstrb = 4'b0101;
      tick();
      we = 0; re_a = 1; raddr_a = 5;
      tick();
      chk("wr_strb", dout_a, 32'hDE22BE44);
      // same-cycle forwarding on both ports
      re_a = 0; we = 1; waddr = 7; data = 32'hAAAAAAAA; wstrb = 4'b1111;
      tick();
      data = 32'h12345678; wstrb = 4'b0011; re_a = 1; re_b = 1; raddr_a = 7; raddr_b = 7;
      tick();
      chk("fwd_a", dout_a, 32'hAAAA5678);
      chk("fwd_b", dout_b, 32'hAAAA5678);
      we = 0; raddr_a = 5;
      tick();
      chk("store_b", dout_b, 32'hAAAA5678);
      chk("other_a", dout_a, 32'hDE22BE44);
      // hardwired zero entry, with and without same-cycle read
      re_a = 0; re_b = 0; we = 1; waddr = 0; data = 32'hFFFFFFFF; wstrb = 4'b1111;
      tick();
      we = 0; re_a = 1; raddr_a = 0;
      tick();
      chk("zero_rd", dout_a, 32'h0);
      re_a = 0; re_b = 1; raddr_b = 5;
      tick();
      we = 1; waddr = 0; re_a = 1; raddr_a = 0; re_b = 1; raddr_b = 0;
      tick();
      chk("zero_fwd_a", dout_a, 32'h0);
      chk("zero_fwd_b", dout_b, 32'h0);
      // hold on port B while writing elsewhere
      we = 1; waddr = 9; data = 32'h0000CAFE; wstrb = 4'b1111; re_a = 0; re_b = 0;
      tick();
      we = 0; re_b = 1; raddr_b = 9;
      tick();
      chk("hold_load", dout_b, 32'h0000CAFE);
      re_b = 0;
      for (int i = 0; i < 4; i++) begin
         raddr_b = 5'(20 + i); we = 1; waddr = 5'(10 + i); data = 32'h5A5A0000 + 32'(i); wstrb = 4'b1111;
         tick();
         chk($sformatf("hold_%0d", i), dout_b, 32'h0000CAFE);
      end
      we = 0; re_a = 1; raddr_a = 12;
      tick();
      chk("hold_wr_ok", dout_a, 32'h5A5A0002);
      // reset in the middle of a write cycle
      re_a = 0; we = 1; waddr = 3; data = 32'h33333333; wstrb = 4'b1111;
      tick();
      we = 0; re_a = 1; raddr_a = 3; re_b = 1; raddr_b = 9;
      tick();
      chk("pre_rst_a", dout_a, 32'h33333333);
      chk("pre_rst_b", dout_b, 32'h0000CAFE);
      we = 1; waddr = 3; data = 32'hFFFFFFFF;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_a", dout_a, 32'h0);
      chk("async_rst_b", dout_b, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      we = 0; re_a = 1; raddr_a = 3; re_b = 1; raddr_b = 9;
      tick();
      chk("post_rst_3", dout_a, 32'h0);
      chk("post_rst_9", dout_b, 32'h0);
      re_a = 0; re_b = 0;
      // ZERO_REG=0: entry 0 is an ordinary register
      n_we = 1; n_waddr = 0; n_data = 32'hFFFFFFFF; n_wstrb = 4'b1111; n_re_a = 1; n_raddr_a = 0;
      tick();
      chk("nz_fwd", n_dout_a, 32'hFFFFFFFF);
      n_we = 0; n_re_a = 0; n_re_b = 1; n_raddr_b = 0;
      tick();
      chk("nz_store", n_dout_b, 32'hFFFFFFFF);
      n_re_b = 0;
      // 16-bit x 8 configuration
      s_we = 1; s_waddr = 5; s_data = 16'hBEEF; s_wstrb = 2'b11;
      tick();
      s_we = 0; s_re_a = 1; s_raddr_a = 5;
      tick();
      chk("s_wr_full", 32'(s_dout_a), 32'h0000BEEF);
      s_re_a = 0; s_we = 1; s_data = 16'h1234; s_wstrb = 2'b01;
      tick();
      s_we = 0; s_re_a = 1;
      tick();
      chk("s_wr_strb", 32'(s_dout_a), 32'h0000BE34);
      s_re_a = 0; s_we = 1; s_waddr = 7; s_data = 16'hAAAA; s_wstrb = 2'b11;
      tick();
      s_data = 16'h5678; s_wstrb = 2'b10; s_re_a = 1; s_re_b = 1; s_raddr_a = 7; s_raddr_b = 7;
      tick();
      chk("s_fwd_a", 32'(s_dout_a), 32'h000056AA);
      chk("s_fwd_b", 32'(s_dout_b), 32'h000056AA);
      s_waddr = 0; s_data = 16'hFFFF; s_wstrb = 2'b11; s_raddr_a = 0;
      tick();
      chk("s_zero_fwd", 32'(s_dout_a), 32'h0);
      s_we = 0;
      tick();
      chk("s_zero_rd", 32'(s_dout_a), 32'h0);
      chk("s_store_b", 32'(s_dout_b), 32'h000056AA);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
